// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control and output bundle of the programmable clock divider
interface clk_div_prog_if #(parameter int CNT_W = 16);
   logic             en;
   logic             sync;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             div_busy;
   logic             div_err;
   logic [CNT_W-1:0] div_cur;
   logic             clk_out;
   logic             tick;
   modport master (output en, sync, div_in, div_load, input div_busy, div_err, div_cur, clk_out, tick);
   modport slave (input en, sync, div_in, div_load, output div_busy, div_err, div_cur, clk_out, tick);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable divider with glitch-free divisor switch, gating and phase sync
module clk_div_prog #(
   parameter int CNT_W       = 16,
   parameter int DIV_DEFAULT = 4
) (
   input logic           clk_in,
   input logic           reset,
   clk_div_prog_if.slave bus
);
   logic [CNT_W-1:0] ph_q, ph_d, d_q, d_d, p_q, p_d, ph_nxt;
   logic             pend_q, pend_d, err_q, err_d, clk_q, clk_d, tick_q, tick_d, bnd, load_ok;
   always_comb begin
      ph_nxt  = (ph_q == d_q - CNT_W'(1)) ? '0 : ph_q + CNT_W'(1);
      bnd     = bus.sync | (bus.en & (ph_nxt == '0));
      // a pending divisor takes effect only at a period boundary, so no pulse is cut short
      d_d     = (bnd & pend_q) ? p_q : d_q;
      ph_d    = bus.sync ? '0 : bus.en ? ph_nxt : ph_q;
      clk_d   = bus.sync | (bus.en ? (ph_nxt < (d_d >> 1)) : clk_q);
      tick_d  = bnd;
      load_ok = bus.div_load & (bus.div_in >= CNT_W'(2));
      p_d     = load_ok ? bus.div_in : p_q;
      pend_d  = load_ok | (pend_q & ~bnd);
      err_d   = bus.div_load & (bus.div_in < CNT_W'(2));
   end
   always_ff @(posedge clk_in) begin
      if (reset) begin
         ph_q   <= CNT_W'(DIV_DEFAULT - 1);
         d_q    <= CNT_W'(DIV_DEFAULT);
         p_q    <= CNT_W'(DIV_DEFAULT);
         pend_q <= 1'b0;
         err_q  <= 1'b0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         ph_q   <= ph_d;
         d_q    <= d_d;
         p_q    <= p_d;
         pend_q <= pend_d;
         err_q  <= err_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end
   assign bus.div_busy = pend_q;
   assign bus.div_err  = err_q;
   assign bus.div_cur  = d_q;
   assign bus.clk_out  = clk_q;
   assign bus.tick     = tick_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed steps with a behavioural model feeding a scoreboard queue
module tb_clk_div_prog;
   logic clk = 1'b0;
   logic reset;
   int total = 0;
   int bad = 0;
   typedef struct {
      logic        clk_out;
      logic        tick;
      logic        busy;
      logic        err;
      logic [15:0] cur;
   } exp_t;
   exp_t sb[$];
   int m_ph, m_d, m_p;
   bit m_pend, m_clk, m_tick, m_err;
   clk_div_prog_if #(.CNT_W(16)) bus ();
   clk_div_prog #(.CNT_W(16), .DIV_DEFAULT(4)) dut (.clk_in(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic model(input bit r, input bit e, input bit s, input bit l, input int di);
      bit bnd;
      if (r) begin
         m_ph = 3; m_d = 4; m_p = 4; m_pend = 0; m_clk = 0; m_tick = 0; m_err = 0;
      end else begin
         m_err = l && di < 2;
         bnd = 0;
         if (s) begin
            m_ph = 0;
            bnd = 1;
         end else if (e) begin
            m_ph = (m_ph + 1) % m_d;
            bnd = (m_ph == 0);
         end
         if (bnd && m_pend) begin
            m_d = m_p;
            m_pend = 0;
         end
         if (s || e) begin
            m_clk = (m_ph < m_d / 2);
            m_tick = bnd;
         end else m_tick = 0;
         if (l && di >= 2) begin
            m_p = di;
            m_pend = 1;
         end
      end
   endtask
   task automatic step(input bit r, input bit e, input bit s, input bit l, input int di);
      exp_t x;
      @(negedge clk);
      reset = r; bus.en = e; bus.sync = s; bus.div_load = l; bus.div_in = 16'(di);
      model(r, e, s, l, di);
      sb.push_back('{m_clk, m_tick, m_pend, m_err, 16'(m_d)});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("clk_out", 32'(bus.clk_out), 32'(x.clk_out));
      chk("tick", 32'(bus.tick), 32'(x.tick));
      chk("div_busy", 32'(bus.div_busy), 32'(x.busy));
      chk("div_err", 32'(bus.div_err), 32'(x.err));
      chk("div_cur", 32'(bus.div_cur), 32'(x.cur));
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
   endtask
   task automatic run_to_ph(input int p);
      int k = 0;
      while (m_ph != p && k < 100) begin
         step(0, 1, 0, 0, 0);
         k++;
      end
      chk("run_to_ph_bound", 32'(m_ph), 32'(p));
   endtask
   initial begin
      bit pat_clk[4];
      bit pat3[3];
      int busy_n;
      logic hold_clk;
      pat_clk = '{1, 1, 0, 0};
      pat3 = '{1, 0, 0};
      reset = 1; bus.en = 0; bus.sync = 0; bus.div_load = 0; bus.div_in = '0;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset_clk_out", 32'(bus.clk_out), 0);
      chk("reset_div_cur", 32'(bus.div_cur), 4);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 0, 0);
         chk("default_pattern", 32'(bus.clk_out), 32'(pat_clk[i % 4]));
         chk("default_tick", 32'(bus.tick), 32'(i % 4 == 0));
      end
      step(0, 1, 0, 1, 5);
      run(14);
      chk("odd_div_cur", 32'(bus.div_cur), 5);
      step(0, 1, 0, 1, 2);
      run(8);
      chk("div2_div_cur", 32'(bus.div_cur), 2);
      step(0, 1, 0, 1, 8);
      run(4);
      chk("div8_div_cur", 32'(bus.div_cur), 8);
      run_to_ph(1);
      step(0, 1, 0, 1, 3);
      busy_n = 1;
      while (bus.div_busy && busy_n < 20) begin
         step(0, 1, 0, 0, 0);
         busy_n += bus.div_busy;
      end
      chk("mid_load_busy_cycles", 32'(busy_n), 6);
      chk("mid_load_applied_tick", 32'(bus.tick), 1);
      for (int i = 1; i < 7; i++) begin
         step(0, 1, 0, 0, 0);
         chk("div3_pattern", 32'(bus.clk_out), 32'(pat3[i % 3]));
      end
      step(0, 1, 0, 1, 1);
      chk("invalid_err_pulse", 32'(bus.div_err), 1);
      chk("invalid_busy", 32'(bus.div_busy), 0);
      step(0, 1, 0, 0, 0);
      chk("invalid_err_clear", 32'(bus.div_err), 0);
      step(0, 1, 0, 1, 6);
      step(0, 1, 0, 1, 7);
      run(8);
      chk("last_load_wins", 32'(bus.div_cur), 7);
      run_to_ph(6);
      step(0, 1, 0, 1, 4);
      chk("bnd_load_nopend_cur", 32'(bus.div_cur), 7);
      chk("bnd_load_nopend_busy", 32'(bus.div_busy), 1);
      run_to_ph(6);
      step(0, 1, 0, 1, 5);
      chk("bnd_load_pend_cur", 32'(bus.div_cur), 4);
      chk("bnd_load_pend_busy", 32'(bus.div_busy), 1);
      run(6);
      chk("bnd_load_followup_cur", 32'(bus.div_cur), 5);
      step(0, 1, 0, 1, 4);
      run(6);
      run_to_ph(1);
      hold_clk = bus.clk_out;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0);
         chk("gated_clk_hold", 32'(bus.clk_out), 32'(hold_clk));
         chk("gated_tick", 32'(bus.tick), 0);
      end
      run(3);
      run_to_ph(1);
      chk("sync_setup_d4", 32'(bus.div_cur), 4);
      step(0, 1, 0, 1, 6);
      step(0, 0, 1, 0, 0);
      chk("sync_clk_out", 32'(bus.clk_out), 1);
      chk("sync_tick", 32'(bus.tick), 1);
      chk("sync_applies_pending", 32'(bus.div_cur), 6);
      run(7);
      step(0, 1, 0, 1, 9);
      run_to_ph(0);
      step(0, 1, 0, 1, 3);
      chk("pre_reset_clk", 32'(bus.clk_out), 1);
      step(1, 1, 0, 0, 0);
      chk("midreset_clk_out", 32'(bus.clk_out), 0);
      chk("midreset_tick", 32'(bus.tick), 0);
      chk("midreset_busy", 32'(bus.div_busy), 0);
      chk("midreset_cur", 32'(bus.div_cur), 4);
      run(8);
      chk("pending_lost", 32'(bus.div_cur), 4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
